gain_mixer_seq: RTL

//  Time-multiplexed N-channel audio mixer with a per-channel gain and a saturating output.
//  One shared MAC accumulates din[ch]*gain[ch] over CHANNELS clocks per sample.
//  It then scales the total and clamps it to DATA_BITS.

---
 rtl/gain_mixer_seq_pkg.sv | 23 ++
 rtl/gain_mixer_seq_signed_saturate.sv | 27 ++
 rtl/gain_mixer_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gain_mixer_seq_pkg.sv
// Shared definitions for the time-multiplexed gain mixer: FSM encoding,
// accumulator sizing and the unity-gain constant.
`ifndef GAIN_MIXER_SEQ_PKG_SV
`define GAIN_MIXER_SEQ_PKG_SV
package gain_mixer_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    // Wide enough that CHANNELS full-scale products at ~2x gain cannot overflow.
    function automatic int acc_bits_f(input int data_bits, input int gain_bits, input int channels);
        return data_bits + gain_bits + $clog2(channels) + 1;
    endfunction

    function automatic int unity_gain_f(input int gain_bits);
        return 1 << (gain_bits - 1);
    endfunction

endpackage
`endif

// File: rtl/gain_mixer_seq_signed_saturate.sv
// Combinational signed clamp from IN_BITS to OUT_BITS, with an out-of-range flag
// so callers can report clipping without a second compare.
module signed_saturate #(
    parameter int IN_BITS  = 24,
    parameter int OUT_BITS = 12
) (
    input  logic [IN_BITS-1:0]  din_i,
    output logic [OUT_BITS-1:0] dout_o,
    output logic                oor_o
);
    localparam logic [OUT_BITS-1:0] MAX_VAL = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic [OUT_BITS-1:0] MIN_VAL = {1'b1, {(OUT_BITS-1){1'b0}}};

    // In range only when every bit above the output sign bit matches it.
    logic [IN_BITS-OUT_BITS:0] top_s;
    assign top_s = din_i[IN_BITS-1:OUT_BITS-1];

    always_comb begin
        oor_o  = !((top_s == '0) || (top_s == '1));
        dout_o = din_i[OUT_BITS-1:0];
        if (oor_o) begin
            dout_o = din_i[IN_BITS-1] ? MIN_VAL : MAX_VAL;
        end else begin
            dout_o = din_i[OUT_BITS-1:0];
        end
    end
endmodule

// File: rtl/gain_mixer_seq.sv
// N-channel audio mixer: one shared MAC sums din*gain over CHANNELS clocks, then
// scales and saturates. Define MIXER_CLIP_DETECT_EN to drive the clip pulse.
module gain_mixer_seq
    import gain_mixer_seq_pkg::*;
#(
    parameter int DATA_BITS = 12,
    parameter int CHANNELS  = 8,
    parameter int GAIN_BITS = 8,
    parameter int OUT_SHIFT = $clog2(CHANNELS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_strobe,
    input  logic [CHANNELS*DATA_BITS-1:0] din,
    input  logic [CHANNELS*GAIN_BITS-1:0] gain,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          dout_valid,
    output logic                          busy,
    output logic                          clip
);
    localparam int ACC_BITS  = acc_bits_f(DATA_BITS, GAIN_BITS, CHANNELS);
    localparam int PROD_BITS = DATA_BITS + GAIN_BITS + 1;
    localparam int EXT_BITS  = ACC_BITS - PROD_BITS;
    localparam int IDX_BITS  = $clog2(CHANNELS);
    localparam int SHIFT     = GAIN_BITS - 1 + OUT_SHIFT;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(CHANNELS - 1);

    state_e                      state_q, state_d;
    logic [DATA_BITS-1:0]        din_q  [CHANNELS];
    logic [GAIN_BITS-1:0]        gain_q [CHANNELS];
    logic signed [ACC_BITS-1:0]  acc_q, acc_d;
    logic [IDX_BITS-1:0]         idx_q, idx_d;
    logic [DATA_BITS-1:0]        dout_q, dout_d;
    logic                        valid_q, valid_d;
    logic                        clip_q, clip_d;
    logic                        busy_q, busy_d;
    logic                        load_s;
    logic signed [PROD_BITS-1:0] prod_s;
    logic signed [ACC_BITS-1:0]  scaled_s;
    logic [DATA_BITS-1:0]        sat_s;
    logic                        clip_flag_s;

    // Gain is unsigned, so widen with a zero sign bit before the signed multiply.
    assign prod_s   = $signed(din_q[idx_q]) * $signed({1'b0, gain_q[idx_q]});
    assign scaled_s = acc_q >>> SHIFT;

`ifdef MIXER_CLIP_DETECT_EN
    logic oor_s;
    signed_saturate #(.IN_BITS(ACC_BITS), .OUT_BITS(DATA_BITS)) u_sat (
        .din_i (scaled_s),
        .dout_o(sat_s),
        .oor_o (oor_s)
    );
    assign clip_flag_s = oor_s;
`else
    logic unused_oor_s;
    signed_saturate #(.IN_BITS(ACC_BITS), .OUT_BITS(DATA_BITS)) u_sat (
        .din_i (scaled_s),
        .dout_o(sat_s),
        .oor_o (unused_oor_s)
    );
    assign clip_flag_s = 1'b0;
`endif

    // Next-state, MAC and output-register logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        clip_d  = 1'b0;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample_strobe) begin
                    load_s  = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + {{EXT_BITS{prod_s[PROD_BITS-1]}}, prod_s};
                idx_d = idx_q + IDX_BITS'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_OUTPUT;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_OUTPUT: begin
                dout_d  = sat_s;
                valid_d = 1'b1;
                clip_d  = clip_flag_s;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            clip_q  <= clip_d;
            busy_q  <= busy_d;
        end
    end

    // Input snapshot; only meaningful once a mix has been accepted.
    always_ff @(posedge clk) begin
        if (load_s) begin
            for (int k = 0; k < CHANNELS; k++) begin
                din_q[k]  <= din[k*DATA_BITS +: DATA_BITS];
                gain_q[k] <= gain[k*GAIN_BITS +: GAIN_BITS];
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign clip       = clip_q;
endmodule
